// File: rtl/tag_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tag_stream_arbiter
//
// Round-robin merge of NUM_SOURCES upstream time-tag word streams onto one
// downstream tag stream. A granted source keeps the grant for up to MAX_BURST
// words. The grant ends early when the source drops valid or is disabled.
// Each new grant costs one IDLE arbitration cycle. Words pass through
// unmodified into a registered output stage. The output stage also carries a
// merged, monotonic lowest-time bound.
//
// Optional feature macro: TAG_STREAM_ARBITER_STATS_EN
//   defined   -> per-source saturating 32-bit accepted-word counters
//   undefined -> stat_words tied to zero, no counter logic
//
// Ports:
//   clk                  stream clock
//   rst_n                asynchronous active-low reset
//   src_enable           per-source arbitration enable
//   s_tvalid / s_tready  upstream handshake, one bit per source
//   s_tkeep              upstream slot-valid masks (WORD_WIDTH per source)
//   s_tagtime            upstream tag times (WORD_WIDTH*TIME_WIDTH per source)
//   s_channel            upstream channels (WORD_WIDTH*CHANNEL_WIDTH per source)
//   s_lowest_time_bound  per-source time bound
//   m_tvalid / m_tready  downstream handshake
//   m_tkeep, m_tagtime, m_channel  downstream word
//   m_lowest_time_bound  merged bound (min over enabled sources, never drops)
//   m_source             source index of the word in the output stage
//   stat_words           per-source accepted-word counters (32 bits each)
// -----------------------------------------------------------------------------
module tag_stream_arbiter #(
    parameter int NUM_SOURCES   = 4,
    parameter int WORD_WIDTH    = 4,
    parameter int TIME_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 6,
    parameter int MAX_BURST     = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_SOURCES-1:0]                      src_enable,
    input  logic [NUM_SOURCES-1:0]                      s_tvalid,
    output logic [NUM_SOURCES-1:0]                      s_tready,
    input  logic [NUM_SOURCES*WORD_WIDTH-1:0]           s_tkeep,
    input  logic [NUM_SOURCES*WORD_WIDTH*TIME_WIDTH-1:0] s_tagtime,
    input  logic [NUM_SOURCES*WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
    input  logic [NUM_SOURCES*TIME_WIDTH-1:0]           s_lowest_time_bound,
    output logic                                        m_tvalid,
    input  logic                                        m_tready,
    output logic [WORD_WIDTH-1:0]                       m_tkeep,
    output logic [WORD_WIDTH*TIME_WIDTH-1:0]            m_tagtime,
    output logic [WORD_WIDTH*CHANNEL_WIDTH-1:0]         m_channel,
    output logic [TIME_WIDTH-1:0]                       m_lowest_time_bound,
    output logic [$clog2(NUM_SOURCES)-1:0]              m_source,
    output logic [NUM_SOURCES*32-1:0]                   stat_words
);

    localparam int IDX_W    = $clog2(NUM_SOURCES);
    localparam int TSLICE_W = WORD_WIDTH * TIME_WIDTH;
    localparam int CSLICE_W = WORD_WIDTH * CHANNEL_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   grant_idx_r, grant_idx_s;
    logic [IDX_W-1:0]   last_idx_r, last_idx_s;
    logic [7:0]         burst_cnt_r, burst_cnt_s;

    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic [IDX_W:0]     cand_sum_s;
    logic [IDX_W-1:0]   cand_s;

    logic               g_valid_s;
    logic               g_en_s;
    logic               out_free_s;
    logic               xfer_s;
    logic               burst_last_s;

    logic [WORD_WIDTH-1:0] sel_keep_s;
    logic [TSLICE_W-1:0]   sel_time_s;
    logic [CSLICE_W-1:0]   sel_chan_s;

    logic                  any_en_s;
    logic [TIME_WIDTH-1:0] min_bound_s;

    // Granted-source view and handshake qualifiers.
    assign g_valid_s    = s_tvalid[grant_idx_r];
    assign g_en_s       = src_enable[grant_idx_r];
    assign out_free_s   = m_tready || !m_tvalid;
    assign xfer_s       = (state_r == ST_GRANT) && g_valid_s && g_en_s && out_free_s;
    assign burst_last_s = (burst_cnt_r == 8'(MAX_BURST - 1));

    assign sel_keep_s = s_tkeep[grant_idx_r*WORD_WIDTH +: WORD_WIDTH];
    assign sel_time_s = s_tagtime[grant_idx_r*TSLICE_W +: TSLICE_W];
    assign sel_chan_s = s_channel[grant_idx_r*CSLICE_W +: CSLICE_W];

    // Round-robin scan: first valid+enabled source after last_idx, wrapping.
    always_comb begin
        found_s    = 1'b0;
        pick_s     = '0;
        cand_sum_s = '0;
        cand_s     = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand_sum_s = {1'b0, last_idx_r} + (IDX_W+1)'(k);
            if (cand_sum_s >= (IDX_W+1)'(NUM_SOURCES)) begin
                cand_sum_s = cand_sum_s - (IDX_W+1)'(NUM_SOURCES);
            end else begin
                cand_sum_s = cand_sum_s;
            end
            cand_s = cand_sum_s[IDX_W-1:0];
            if (!found_s && s_tvalid[cand_s] && src_enable[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
                pick_s  = pick_s;
            end
        end
    end

    // Upstream ready: only the granted source, and only when the output stage can take a word.
    always_comb begin
        s_tready = '0;
        if (state_r == ST_GRANT) begin
            s_tready[grant_idx_r] = g_en_s && out_free_s;
        end else begin
            s_tready = '0;
        end
    end

    // Next-state logic for the grant FSM and its bookkeeping registers.
    always_comb begin
        state_s     = state_r;
        grant_idx_s = grant_idx_r;
        last_idx_s  = last_idx_r;
        burst_cnt_s = burst_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s     = ST_GRANT;
                    grant_idx_s = pick_s;
                    burst_cnt_s = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (xfer_s) begin
                    burst_cnt_s = burst_cnt_r + 8'd1;
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
                // A stalled-but-valid source keeps its grant; a drop of valid
                // or enable ends the burst.
                if ((xfer_s && burst_last_s) || !g_valid_s || !g_en_s) begin
                    state_s    = ST_IDLE;
                    last_idx_s = grant_idx_r;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and arbitration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            grant_idx_r <= '0;
            last_idx_r  <= IDX_W'(NUM_SOURCES - 1);
            burst_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            grant_idx_r <= grant_idx_s;
            last_idx_r  <= last_idx_s;
            burst_cnt_r <= burst_cnt_s;
        end
    end

    // Output stage: load on transfer, retire on downstream handshake, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid  <= 1'b0;
            m_tkeep   <= '0;
            m_tagtime <= '0;
            m_channel <= '0;
            m_source  <= '0;
        end else if (xfer_s) begin
            m_tvalid  <= 1'b1;
            m_tkeep   <= sel_keep_s;
            m_tagtime <= sel_time_s;
            m_channel <= sel_chan_s;
            m_source  <= grant_idx_r;
        end else if (out_free_s) begin
            m_tvalid  <= 1'b0;
        end else begin
            m_tvalid  <= m_tvalid;
        end
    end

    // Unsigned minimum of the bounds of all enabled sources.
    always_comb begin
        any_en_s    = |src_enable;
        min_bound_s = '1;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (src_enable[i] && (s_lowest_time_bound[i*TIME_WIDTH +: TIME_WIDTH] < min_bound_s)) begin
                min_bound_s = s_lowest_time_bound[i*TIME_WIDTH +: TIME_WIDTH];
            end else begin
                min_bound_s = min_bound_s;
            end
        end
    end

    // Merged bound register: follows the minimum but never moves backwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lowest_time_bound <= '0;
        end else if (any_en_s && (min_bound_s >= m_lowest_time_bound)) begin
            m_lowest_time_bound <= min_bound_s;
        end else begin
            m_lowest_time_bound <= m_lowest_time_bound;
        end
    end

`ifdef TAG_STREAM_ARBITER_STATS_EN
    logic [31:0] stat_cnt_r [NUM_SOURCES];

    // Per-source saturating count of accepted upstream words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                stat_cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (xfer_s && (grant_idx_r == IDX_W'(i)) && (stat_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    stat_cnt_r[i] <= stat_cnt_r[i] + 32'd1;
                end else begin
                    stat_cnt_r[i] <= stat_cnt_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_stat
        assign stat_words[g*32 +: 32] = stat_cnt_r[g];
    end
`else
    assign stat_words = '0;
`endif

endmodule
